// File: rtl/mux_alternante_if.sv
// mux_alternante_if: two input lanes with ready backpressure plus the merged output stream.
// drop_cnt exists only when MUX_DROP_CNT_EN is defined.
interface mux_alternante_if #(parameter int BW = 4);
  logic          valid_0;
  logic [BW-1:0] data_in0;
  logic          valid_1;
  logic [BW-1:0] data_in1;
  logic          ready_0;
  logic          ready_1;
  logic          valid_out;
  logic [BW-1:0] data_out;
`ifdef MUX_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif
  modport master (
`ifdef MUX_DROP_CNT_EN
    input  drop_cnt,
`endif
    output valid_0, data_in0, valid_1, data_in1,
    input  ready_0, ready_1, valid_out, data_out
  );
  modport slave (
`ifdef MUX_DROP_CNT_EN
    output drop_cnt,
`endif
    input  valid_0, data_in0, valid_1, data_in1,
    output ready_0, ready_1, valid_out, data_out
  );
endinterface

// File: rtl/mux_alternante.sv
// mux_alternante: merges two FIFO-buffered lanes into one stream, popping lane 0 and lane 1 in strict alternation.
// Optional saturating drop counter enabled by defining MUX_DROP_CNT_EN.
module mux_alternante #(
  parameter int BW    = 4,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_L,
  mux_alternante_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {SEL0, SEL1} state_t;
  state_t        state, state_nxt;
  logic [BW-1:0] mem0 [DEPTH];
  logic [BW-1:0] mem1 [DEPTH];
  logic [PW-1:0] wr0, rd0, wr1, rd1;
  logic [CW-1:0] cnt0, cnt1;
  logic          push0, push1, pop0, pop1;
  logic          valid_q;
  logic [BW-1:0] data_q, data_nxt;
  assign bus.ready_0   = cnt0 != CW'(DEPTH);
  assign bus.ready_1   = cnt1 != CW'(DEPTH);
  assign push0         = bus.valid_0 & bus.ready_0;
  assign push1         = bus.valid_1 & bus.ready_1;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) state <= SEL0;
    else          state <= state_nxt;
  // the arbiter waits on the selected lane even when the other lane holds data
  always_comb begin
    pop0      = state == SEL0 && cnt0 != '0;
    pop1      = state == SEL1 && cnt1 != '0;
    state_nxt = pop0 ? SEL1 : pop1 ? SEL0 : state;
    data_nxt  = pop0 ? mem0[rd0] : pop1 ? mem1[rd1] : '0;
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      wr0     <= '0;
      rd0     <= '0;
      cnt0    <= '0;
      wr1     <= '0;
      rd1     <= '0;
      cnt1    <= '0;
    end else begin
      valid_q <= pop0 | pop1;
      data_q  <= data_nxt;
      wr0     <= wr0 + PW'(push0);
      rd0     <= rd0 + PW'(pop0);
      cnt0    <= cnt0 + CW'(push0) - CW'(pop0);
      wr1     <= wr1 + PW'(push1);
      rd1     <= rd1 + PW'(pop1);
      cnt1    <= cnt1 + CW'(push1) - CW'(pop1);
    end
  always_ff @(posedge clk) begin
    if (push0) mem0[wr0] <= bus.data_in0;
    if (push1) mem1[wr1] <= bus.data_in1;
  end
`ifdef MUX_DROP_CNT_EN
  logic [7:0] drop_q;
  logic [8:0] drop_sum;
  assign drop_sum     = {1'b0, drop_q} + 9'(bus.valid_0 & ~bus.ready_0) + 9'(bus.valid_1 & ~bus.ready_1);
  assign bus.drop_cnt = drop_q;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) drop_q <= '0;
    else          drop_q <= drop_sum[8] ? 8'hff : drop_sum[7:0];
`endif
endmodule

// File: tb/tb_mux_alternante.sv
// tb_mux_alternante: queue-based reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_mux_alternante;
  localparam int BW = 4, DEPTH = 2;
  logic clk = 1'b0, reset_L = 1'b0;
  always #5 clk = ~clk;
  mux_alternante_if #(.BW(BW)) bus ();
  mux_alternante #(.BW(BW), .DEPTH(DEPTH)) dut (.clk(clk), .reset_L(reset_L), .bus(bus));
  int tests = 0, fails = 0;
  logic [BW-1:0] q0[$], q1[$];
  bit sel, r0, r1;
  logic ev;
  logic [BW-1:0] ed;
  int drops;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // reference model: lane queues, a lane selector bit, and a drop tally
  always @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      q0.delete(); q1.delete(); sel = 0; ev = 0; ed = '0; drops = 0;
    end else begin
      r0 = q0.size() < DEPTH;
      r1 = q1.size() < DEPTH;
      if (!sel && q0.size() > 0) begin ed = q0.pop_front(); ev = 1; sel = 1; end
      else if (sel && q1.size() > 0) begin ed = q1.pop_front(); ev = 1; sel = 0; end
      else begin ev = 0; ed = '0; end
      if (bus.valid_0) begin if (r0) q0.push_back(bus.data_in0); else drops++; end
      if (bus.valid_1) begin if (r1) q1.push_back(bus.data_in1); else drops++; end
      if (drops > 255) drops = 255;
    end
  always @(negedge clk) begin
    chk("valid_out", 32'(bus.valid_out), 32'(ev));
    chk("data_out", 32'(bus.data_out), 32'(ed));
    chk("ready_0", 32'(bus.ready_0), 32'(q0.size() < DEPTH));
    chk("ready_1", 32'(bus.ready_1), 32'(q1.size() < DEPTH));
`ifdef MUX_DROP_CNT_EN
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(drops));
`endif
  end
  task automatic cyc(input bit v0, input logic [BW-1:0] d0, input bit v1, input logic [BW-1:0] d1);
    @(negedge clk); #1;
    bus.valid_0 = v0; bus.data_in0 = d0; bus.valid_1 = v1; bus.data_in1 = d1;
  endtask
  task automatic idle(); cyc(0, '0, 0, '0); endtask
  task automatic out(input string name, input logic v, input logic [BW-1:0] d);
    chk({name, "_valid"}, 32'(bus.valid_out), 32'(v));
    chk({name, "_data"}, 32'(bus.data_out), 32'(d));
  endtask
  task automatic do_reset();
    @(negedge clk); #1 reset_L = 1'b0;
    bus.valid_0 = 0; bus.valid_1 = 0;
    @(negedge clk); #1 reset_L = 1'b1;
  endtask
  initial begin
    bus.valid_0 = 1; bus.data_in0 = 4'hA; bus.valid_1 = 0; bus.data_in1 = '0;
    repeat (3) @(negedge clk);
    #1 out("rst", 0, 0);
    chk("rst_ready_0", 32'(bus.ready_0), 1);
    chk("rst_ready_1", 32'(bus.ready_1), 1);
    reset_L = 1'b1; bus.valid_0 = 0;
    repeat (3) idle();
    out("rst_after", 0, 0);
    // paired stream
    cyc(1, 4'hA, 1, 4'h5);
    cyc(1, 4'h3, 1, 4'hC); out("pair0", 0, 0);
    idle(); out("pair1", 1, 4'hA);
    idle(); out("pair2", 1, 4'h5);
    idle(); out("pair3", 1, 4'h3);
    idle(); out("pair4", 1, 4'hC);
    idle(); out("pair5", 0, 0);
    // skew: lane 1 idle, arbiter must wait in SEL1
    do_reset();
    cyc(1, 4'h1, 0, 0);
    cyc(1, 4'h2, 0, 0);
    idle(); out("skew1", 1, 4'h1);
    idle(); out("skew_hold", 0, 0);
    cyc(0, 0, 1, 4'h7); out("skew_hold2", 0, 0);
    idle(); out("skew_hold3", 0, 0);
    idle(); out("skew7", 1, 4'h7);
    idle(); out("skew2", 1, 4'h2);
    idle(); out("skew_end", 0, 0);
    // overflow on lane 0 while the arbiter holds in SEL1
    do_reset();
    cyc(1, 4'h1, 0, 0);
    cyc(1, 4'h2, 0, 0);
    cyc(1, 4'h3, 0, 0); out("ovf1", 1, 4'h1);
    cyc(1, 4'h4, 0, 0); out("ovf_hold", 0, 0);
    chk("ovf_ready_0", 32'(bus.ready_0), 0);
    cyc(0, 0, 1, 4'h8); chk("ovf_ready_0b", 32'(bus.ready_0), 0);
`ifdef MUX_DROP_CNT_EN
    chk("ovf_drop_cnt", 32'(bus.drop_cnt), 1);
`endif
    idle(); out("ovf_hold2", 0, 0);
    idle(); out("ovf8", 1, 4'h8);
    idle(); out("ovf2", 1, 4'h2);
    chk("ovf_ready_0c", 32'(bus.ready_0), 1);
    idle(); out("ovf_end", 0, 0);
    // full lane 0 popped on the same edge a push is offered: the push is rejected
    do_reset();
    cyc(1, 4'h1, 0, 0);
    cyc(1, 4'h2, 0, 0);
    cyc(1, 4'h3, 0, 0);
    cyc(0, 0, 1, 4'h6);
    idle();
    cyc(1, 4'h9, 0, 0); out("fp6", 1, 4'h6);
    chk("fp_ready_full", 32'(bus.ready_0), 0);
    idle(); out("fp2", 1, 4'h2);
    chk("fp_ready_after", 32'(bus.ready_0), 1);
    cyc(0, 0, 1, 4'h1); out("fp_hold", 0, 0);
    idle();
    idle(); out("fp1", 1, 4'h1);
    idle(); out("fp3", 1, 4'h3);
    idle(); out("fp_end", 0, 0);
    // asynchronous reset between edges with words queued
    do_reset();
    cyc(1, 4'h1, 1, 4'h2);
    cyc(1, 4'h3, 0, 0);
    idle(); out("ar1", 1, 4'h1);
    #2 reset_L = 1'b0;
    #1 out("ar_async", 0, 0);
    chk("ar_ready_0", 32'(bus.ready_0), 1);
    chk("ar_ready_1", 32'(bus.ready_1), 1);
    @(negedge clk); #1 reset_L = 1'b1;
    repeat (3) begin idle(); out("ar_empty", 0, 0); end
    cyc(0, 0, 1, 4'hE);
    idle(); out("ar_sel0_wait", 0, 0);
    cyc(1, 4'h5, 0, 0);
    idle(); out("ar_wait2", 0, 0);
    idle(); out("ar5", 1, 4'h5);
    idle(); out("arE", 1, 4'hE);
`ifdef MUX_DROP_CNT_EN
    // saturation of the drop counter
    do_reset();
    cyc(1, 4'h1, 0, 0);
    cyc(1, 4'h2, 0, 0);
    repeat (300) cyc(1, 4'h4, 0, 0);
    chk("drop_sat", 32'(bus.drop_cnt), 255);
`endif
    idle(); idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
